// File: rtl/note_sched_pkg.sv
// rtl/note_sched_pkg.sv - note scheduler state encoding, note word layout and tick rate
package note_sched_pkg;

    localparam int TICK_HZ  = 1000;

    localparam int FREQ_LSB = 0;
    localparam int FREQ_MSB = 11;
    localparam int DUR_LSB  = 12;
    localparam int DUR_MSB  = 27;
    localparam int FREQ_W   = FREQ_MSB - FREQ_LSB + 1;
    localparam int DUR_W    = DUR_MSB - DUR_LSB + 1;
    localparam int ENTRY_W  = DUR_MSB + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

endpackage

// File: rtl/note_scheduler_if.sv
// rtl/note_scheduler_if.sv - CPU-side note queue write port and status
interface note_sched_if #(
    parameter int DEPTH = 8
);
    logic                   wr_en;
    logic [31:0]            wr_data;
    logic                   stop;
    logic                   wr_ready;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;

    modport master (
        output wr_en, wr_data, stop,
        input  wr_ready, count, overflow
    );

    modport slave (
        input  wr_en, wr_data, stop,
        output wr_ready, count, overflow
    );
endinterface

// File: rtl/note_fifo.sv
// rtl/note_fifo.sv - synchronous note queue with flush; head word visible combinationally
module note_fifo
    import note_sched_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = ENTRY_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/note_scheduler.sv
// rtl/note_scheduler.sv - timed note playback from a queue; GAP silence built when NOTE_SCHED_GAP_EN is defined
module note_scheduler
    import note_sched_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int DEPTH  = 8,
    parameter int GAP_MS = 20
) (
    input  logic               clock,
    input  logic               reset,
    note_sched_if.slave        bus,
    output logic               busy,
    output logic [FREQ_W-1:0]  tone_freq,
    output logic               note_done
);
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW       = $clog2(DEPTH) + 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_e             state_q, state_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic [DUR_W-1:0]   ms_q, ms_d;
    logic [FREQ_W-1:0]  tone_q, tone_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;

    logic               push, pop;
    logic               fifo_full, fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic [ENTRY_W-1:0] head;
    logic [FREQ_W-1:0]  head_freq;
    logic [DUR_W-1:0]   head_dur;
    logic               more_next;
    logic               tick;
    logic               unused_bits;

    assign unused_bits = ^bus.wr_data[31:ENTRY_W];

    note_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clock),
        .rst_n (reset),
        .flush (bus.stop),
        .push  (push),
        .pop   (pop),
        .din   (bus.wr_data[ENTRY_W-1:0]),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head_freq = head[FREQ_MSB:FREQ_LSB];
    assign head_dur  = head[DUR_MSB:DUR_LSB];
    assign push      = bus.wr_en & ~fifo_full & ~bus.stop;
    assign pop       = (state_q == ST_LOAD) & ~bus.stop;
    assign tick      = (presc_q == PRESC_LAST);

    // Queue occupancy after this edge, so a write landing now is seen immediately
    assign more_next = push | (pop ? (fifo_count > CW'(1)) : ~fifo_empty);

    assign bus.wr_ready = ~fifo_full;
    assign bus.count    = fifo_count;
    assign bus.overflow = ovf_q;
    assign busy         = (state_q != ST_IDLE);
    assign tone_freq    = tone_q;
    assign note_done    = done_q;

`ifndef NOTE_SCHED_GAP_EN
    logic unused_gap;
    assign unused_gap = (GAP_MS != 0);
`endif

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        ms_d    = ms_q;
        tone_d  = tone_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q | (bus.wr_en & fifo_full);
        if (bus.stop) begin
            state_d = ST_IDLE;
            presc_d = '0;
            ms_d    = '0;
            tone_d  = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (more_next) state_d = ST_LOAD;
                end
                ST_LOAD: begin
                    if (head_dur != '0) begin
                        state_d = ST_PLAY;
                        presc_d = '0;
                        ms_d    = head_dur;
                        tone_d  = head_freq;
                    end else begin
                        done_d  = 1'b1;
                        state_d = more_next ? ST_LOAD : ST_IDLE;
                    end
                end
                ST_PLAY: begin
                    if (tick) begin
                        presc_d = '0;
                        if (ms_q == DUR_W'(1)) begin
                            done_d = 1'b1;
                            tone_d = '0;
`ifdef NOTE_SCHED_GAP_EN
                            if (GAP_MS > 0) begin
                                state_d = ST_GAP;
                                ms_d    = DUR_W'(GAP_MS);
                            end else begin
                                state_d = more_next ? ST_LOAD : ST_IDLE;
                            end
`else
                            state_d = more_next ? ST_LOAD : ST_IDLE;
`endif
                        end else begin
                            ms_d = ms_q - DUR_W'(1);
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
`ifdef NOTE_SCHED_GAP_EN
                ST_GAP: begin
                    if (tick) begin
                        presc_d = '0;
                        if (ms_q == DUR_W'(1)) begin
                            state_d = more_next ? ST_LOAD : ST_IDLE;
                        end else begin
                            ms_d = ms_q - DUR_W'(1);
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            ms_q    <= '0;
            tone_q  <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            ms_q    <= ms_d;
            tone_q  <= tone_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_note_scheduler.sv
// tb/tb_note_scheduler.sv - scoreboard bench for note_scheduler (gap length follows NOTE_SCHED_GAP_EN)
module tb_note_scheduler;

    localparam int DEPTH = 4;
`ifdef NOTE_SCHED_GAP_EN
    localparam int G = 20;
`else
    localparam int G = 0;
`endif

    typedef struct {
        int freq;
        int start;
        int len;
    } seg_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        busy;
    logic        note_done;
    logic [11:0] tone_freq;

    note_sched_if #(.DEPTH(DEPTH)) bus();

    note_scheduler #(
        .CLK_HZ (10000),
        .DEPTH  (DEPTH),
        .GAP_MS (2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .busy      (busy),
        .tone_freq (tone_freq),
        .note_done (note_done)
    );

    int   cyc   = 0;
    int   nvec  = 0;
    int   nfail = 0;
    seg_t exp_seg[$];
    int   exp_done[$];
    int   prev_tone = 0;
    int   seg_start = 0;
    seg_t s;
    int   d;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Tone segments and note_done pulses are matched against expectations in order
    always @(negedge clock) begin
        if (int'(tone_freq) != prev_tone) begin
            if (prev_tone != 0) begin
                if (exp_seg.size() == 0) begin
                    check("unexpected_tone", prev_tone, 0);
                end else begin
                    s = exp_seg.pop_front();
                    check("seg_freq", prev_tone, s.freq);
                    check("seg_start", seg_start, s.start);
                    check("seg_len", cyc - seg_start, s.len);
                end
            end
            if (tone_freq != 12'd0) seg_start = cyc;
            prev_tone = int'(tone_freq);
        end
        if (note_done) begin
            if (exp_done.size() == 0) begin
                check("unexpected_done", cyc, -1);
            end else begin
                d = exp_done.pop_front();
                check("done_cycle", cyc, d);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic at_cycle(input int c);
        while (cyc < c) step();
    endtask

    task automatic wr(input logic [31:0] w);
        bus.wr_en   = 1'b1;
        bus.wr_data = w;
        step();
        bus.wr_en   = 1'b0;
    endtask

    function automatic logic [31:0] note_word(input int f, input int ms);
        return {4'h0, 16'(ms), 12'(f)};
    endfunction

    task automatic expect_note(input int f, input int start, input int len, input int done);
        seg_t e;
        e.freq  = f;
        e.start = start;
        e.len   = len;
        exp_seg.push_back(e);
        if (done >= 0) exp_done.push_back(done);
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (busy && n < bound) begin
            step();
            n++;
        end
        check("idle_timeout", int'(busy), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_tone"},     int'(tone_freq), 0);
        check({tag, "_done"},     int'(note_done), 0);
        check({tag, "_busy"},     int'(busy), 0);
        check({tag, "_count"},    int'(bus.count), 0);
        check({tag, "_wr_ready"}, int'(bus.wr_ready), 1);
        check({tag, "_overflow"}, int'(bus.overflow), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        bus.wr_en   = 1'b0;
        bus.wr_data = 32'h0;
        bus.stop    = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_vals("reset");
        reset = 1'b1;
        step();

        // Single 440 Hz, 1 ms note
        t0 = cyc;
        expect_note(440, t0 + 2, 10, t0 + 12);
        wr(32'h0000_11B8);
        at_cycle(t0 + 11 + G);
        check("busy_before_idle", int'(busy), 1);
        step();
        check("idle_after_note", int'(busy), 0);

        // Five back-to-back writes plus one into a full queue
        step();
        t0 = cyc;
        for (int k = 0; k < 5; k++)
            expect_note(100 * (k + 1), t0 + 2 + k * (11 + G), 10, t0 + 12 + k * (11 + G));
        for (int k = 0; k < 5; k++) begin
            wr(note_word(100 * (k + 1), 1));
            if (k == 3) begin
                check("count_3", int'(bus.count), 3);
                check("wr_ready_at_3", int'(bus.wr_ready), 1);
            end
        end
        check("count_full", int'(bus.count), 4);
        check("wr_ready_full", int'(bus.wr_ready), 0);
        check("overflow_pre", int'(bus.overflow), 0);
        wr(note_word(600, 1));
        check("overflow_set", int'(bus.overflow), 1);
        check("count_after_drop", int'(bus.count), 4);
        wait_idle(400);

        // Asynchronous reset mid-note
        step();
        t0 = cyc;
        check("ovf_before_reset", int'(bus.overflow), 1);
        expect_note(200, t0 + 2, 3, -1);
        wr(note_word(200, 1));
        at_cycle(t0 + 5);
        check("tone_before_reset", int'(tone_freq), 200);
        reset = 1'b0;
        #1;
        check_reset_vals("async_reset");
        step();
        step();
        reset = 1'b1;
        step();

        // Zero-duration note followed by 262 Hz
        t0 = cyc;
        exp_done.push_back(t0 + 2);
        expect_note(262, t0 + 3, 10, t0 + 13);
        wr(32'h0000_0123);
        wr(32'h0000_1106);
        wait_idle(100);

        // Two 1 ms notes: silence between them is one LOAD cycle plus any gap
        step();
        t0 = cyc;
        expect_note(1000, t0 + 2, 10, t0 + 12);
        expect_note(1500, t0 + 13 + G, 10, t0 + 23 + G);
        wr(32'h0000_13E8);
        wr(32'h0000_15DC);
        wait_idle(100);

        // Stop mid-play with a full queue and overflow set; write in stop cycle
        step();
        t0 = cyc;
        expect_note(700, t0 + 2, 5, -1);
        for (int k = 0; k < 6; k++) wr(note_word(700 + 100 * k, 2));
        check("stop_pre_count", int'(bus.count), 4);
        check("stop_pre_ovf", int'(bus.overflow), 1);
        check("stop_pre_tone", int'(tone_freq), 700);
        bus.stop    = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_data = note_word(1234, 1);
        step();
        bus.stop    = 1'b0;
        bus.wr_en   = 1'b0;
        check_reset_vals("after_stop");
        repeat (30) step();
        check("stop_stays_idle", int'(busy), 0);
        check("stop_stays_empty", int'(bus.count), 0);

        check("segs_left", exp_seg.size(), 0);
        check("dones_left", exp_done.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/note_scheduler.md
NOTE_SCHEDULER -- requirements
Module: note_scheduler

Interface
REQ-001 Parameter: CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter: DEPTH, default 8, note-queue depth (power of two, >=2).
REQ-003 Parameter: GAP_MS, default 20, silence inserted between notes (used only when NOTE_SCHED_GAP_EN is defined).
REQ-004 Port: clock  in  1  system clock, all logic on rising edge.
REQ-005 Port: reset  in  1  asynchronous, active-low reset.
REQ-006 Port: wr_en  in  1  CPU MMIO write strobe to the note queue.
REQ-007 Port: wr_data  in  32  note word: [11:0] frequency Hz (0 = rest), [27:12] duration ms, [31:28] ignored.
REQ-008 Port: stop  in  1  synchronous flush-and-silence request.
REQ-009 Port: wr_ready  out  1  queue not full.
REQ-010 Port: count  out  $clog2(DEPTH)+1  queued notes, excluding the note playing.
REQ-011 Port: busy  out  1  state != IDLE.
REQ-012 Port: tone_freq  out  12  frequency to the tone generator; 0 = silence.
REQ-013 Port: note_done  out  1  one-cycle pulse per consumed note.
REQ-014 Port: overflow  out  1  sticky flag: a write was dropped.

Function
REQ-015 TICK_DIV = CLK_HZ/1000 (integer); a ms prescaler counts 0..TICK_DIV-1 and restarts on every entry to PLAY or GAP.
REQ-016 States: IDLE, LOAD, PLAY, GAP; IDLE->LOAD when queue non-empty; LOAD pops one entry in one cycle.
REQ-017 LOAD->PLAY when duration != 0; LOAD with duration 0 pulses note_done next cycle, plays nothing, goes to LOAD if queue non-empty, else IDLE.
REQ-018 tone_freq takes the note frequency on the edge entering PLAY and holds for exactly duration*TICK_DIV cycles.
REQ-019 On PLAY expiry: note_done pulses in the following cycle, tone_freq is 0, next state GAP (macro on, GAP_MS>0), else LOAD if non-empty, else IDLE.
REQ-020 GAP holds tone_freq 0 for exactly GAP_MS*TICK_DIV cycles, then LOAD if non-empty, else IDLE.
REQ-021 Latency: write in cycle n to an empty, idle block -> LOAD at n+1, tone_freq valid from n+2.
REQ-022 Write with wr_ready=0 is dropped and sets overflow, even if a pop occurs in the same cycle.
REQ-023 Simultaneous write and pop with queue not full: both occur; count unchanged.
REQ-024 Queue pointers wrap modulo DEPTH; count saturates at DEPTH only via REQ-022.
REQ-025 stop has top priority: next edge empties the queue, state IDLE, tone_freq 0, overflow cleared, no note_done; a write in the stop cycle is dropped without setting overflow.
REQ-026 Rest notes (frequency 0) time normally in PLAY with tone_freq 0.

Reset
REQ-027 On reset low: state IDLE, queue empty, count 0, tone_freq 0, note_done 0, overflow 0, wr_ready 1, busy 0, prescaler 0.
REQ-028 Reset asserted mid-note silences tone_freq immediately (asynchronous); deassertion is synchronised to clock by the instantiating design.

Configuration
REQ-029 Macro NOTE_SCHED_GAP_EN defined: GAP state and GAP_MS are active per REQ-019/020.
REQ-030 Macro NOTE_SCHED_GAP_EN undefined: GAP state is not built, GAP_MS is ignored, and PLAY expiry goes directly to LOAD/IDLE (notes back-to-back with one LOAD cycle of silence).

Structure
REQ-031 Package note_sched_pkg holds the state enum, the wr_data field positions/widths (FREQ_LSB/MSB, DUR_LSB/MSB), and the 1000 Hz tick constant.
REQ-032 Sub-module note_fifo (synchronous FIFO, DEPTH x 28 bits, push/pop/full/empty/count) is instantiated once; control FSM and timers remain in note_scheduler.

Verification (CLK_HZ=10000 -> TICK_DIV=10, DEPTH=4, GAP_MS=2, macro defined unless stated)
REQ-033 Write 0x00001_1B8 (440 Hz, 1 ms) at cycle 0 -> tone_freq=440 in cycles 2..11, note_done at 12, tone_freq=0 for 20 cycles, then IDLE, busy=0.
REQ-034 Write 5 notes back-to-back while idle -> first plays, 4 queue, wr_ready=0 only when count=4; an extra write while full sets overflow=1 and that note never plays.
REQ-035 Write duration-0 note followed by a 262 Hz, 1 ms note -> note_done for the first with no nonzero tone, 262 Hz plays for exactly 10 cycles.
REQ-036 Assert stop mid-PLAY with 2 queued -> next cycle tone_freq=0, count=0, busy=0, overflow=0, no note_done.
REQ-037 Macro undefined: two 1 ms notes -> exactly one silent cycle (LOAD) between them; assert reset low mid-note -> all outputs at reset values without a clock edge.
